// File: rtl/kf_fxp_pkg.sv
// Fixed-point helpers shared by the Kalman-gain engine.
//   N_DEF / FRAC_DEF : default word width and fractional bits (Q10.10)
//   MAX_N / MIN_N    : clamp limits for the default N-bit word
//   state_e          : sequencer states of kgain_serial
//   sat_n()          : clamp a wide signed value to an n-bit signed range
package kf_fxp_pkg;
  localparam int N_DEF    = 20;
  localparam int FRAC_DEF = 10;
  // Wide enough for any intermediate of an N<=32 datapath.
  localparam int SAT_W    = 128;

  localparam logic signed [N_DEF-1:0] MAX_N = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic signed [N_DEF-1:0] MIN_N = {1'b1, {(N_DEF-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SUM, DET0, DET1, MUL, DIV, DONE} state_e;

  // Clamp x to [-2^(n-1), 2^(n-1)-1]; caller truncates the result to n bits.
  function automatic logic signed [SAT_W-1:0] sat_n(input logic signed [SAT_W-1:0] x,
                                                    input int n);
    logic signed [SAT_W-1:0] hi, lo;
    hi = {{(SAT_W-1){1'b0}}, 1'b1};
    hi = (hi <<< (n - 1)) - 1;
    lo = -hi - 1;
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction
endpackage

// File: rtl/fxp_div_serial.sv
// Signed serial restoring divider: q = sat_N(num / den), truncated toward zero.
//   start : load num/den (ignored while busy)
//   num   : 2N-bit signed dividend; magnitude expected below 2^(N+FRAC)
//   den   : N-bit signed divisor
//   busy  : high for the N+FRAC iteration cycles after the load cycle
//   valid : high in the final iteration cycle; q is valid only then
//   q     : N-bit signed saturated quotient
module fxp_div_serial
  import kf_fxp_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [2*N-1:0] num,
  input  logic signed [N-1:0]   den,
  output logic                  busy,
  output logic                  valid,
  output logic signed [N-1:0]   q
);
  localparam int QW = N + FRAC;
  localparam int CW = $clog2(QW);

  logic [N-1:0]  rem_q, rem_d, den_q, den_d, rem_nx, den_mag;
  logic [QW-1:0] quo_q, quo_d, quo_nx, mag;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, neg_q, neg_d, ovf_q, ovf_d, fit;
  logic [2*N-1:0] num_mag;
  logic [N:0]     shl;
  logic signed [SAT_W-1:0] qs;

  always_comb begin
    num_mag = num[2*N-1] ? (~num + 1'b1) : num;
    den_mag = den[N-1]   ? (~den + 1'b1) : den;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    shl    = {rem_q, quo_q[QW-1]};
    fit    = (shl >= {1'b0, den_q});
    rem_nx = fit ? (shl[N-1:0] - den_q) : shl[N-1:0];
    quo_nx = {quo_q[QW-2:0], fit};

    // An out-of-range dividend is clamped rather than wrapped.
    mag = ovf_q ? '1 : quo_nx;
    qs  = {{(SAT_W-QW){1'b0}}, mag};
    if (neg_q) qs = -qs;
    q     = N'(sat_n(qs, N));
    valid = busy_q && (cnt_q == CW'(QW - 1));
    busy  = busy_q;

    busy_d = busy_q; cnt_d = cnt_q; rem_d = rem_q; quo_d = quo_q;
    den_d  = den_q;  neg_d = neg_q; ovf_d = ovf_q;
    if (busy_q) begin
      rem_d = rem_nx;
      quo_d = quo_nx;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(QW - 1)) busy_d = 1'b0;
    end else if (start) begin
      rem_d  = '0;
      quo_d  = num_mag[QW-1:0];
      den_d  = den_mag;
      neg_d  = num[2*N-1] ^ den[N-1];
      ovf_d  = |num_mag[2*N-1:QW];
      cnt_d  = '0;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0; cnt_q <= '0; rem_q <= '0; quo_q <= '0;
      den_q  <= '0;   neg_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      busy_q <= busy_d; cnt_q <= cnt_d; rem_q <= rem_d; quo_q <= quo_d;
      den_q  <= den_d;  neg_q <= neg_d; ovf_q <= ovf_d;
    end
  end
endmodule

// File: rtl/kgain_serial.sv
// Serial Kalman gain for a 2x2 filter with H = I: K = P * adj(P+R) / det(P+R).
//   start            : one-cycle request, accepted only when idle
//   P00..P11         : predicted covariance, Q(N-FRAC).FRAC
//   R11..R22         : measurement noise (R11 pairs with P00), same format
//   busy             : job in flight (cycles after accept up to done)
//   done             : one-cycle pulse; K*/singular change only here
//   singular         : det(S) <= 0 on the last job (K forced to 0)
//   K00..K11         : gain, Q(N-FRAC).FRAC
module kgain_serial
  import kf_fxp_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] P00, P01, P10, P11,
  input  logic signed [N-1:0] R11, R12, R21, R22,
  output logic                busy,
  output logic                done,
  output logic                singular,
  output logic signed [N-1:0] K00, K01, K10, K11
);
  state_e state_q, state_d;

  logic signed [N-1:0] p_q [4], p_d [4], r_q [4], r_d [4], s_q [4], s_d [4];
  logic signed [N-1:0] n_q [4], n_d [4], k_q [4], k_d [4], kt_q [3], kt_d [3];
  logic signed [N-1:0] det_q, det_d, det_nx, mul_a, mul_b;
  logic signed [2*N:0] acc_q, acc_d, prod_x, term, sum, diff, shr_sum, shr_det;
  logic signed [2*N-1:0] prod, div_ext, div_num;
  logic signed [N:0]   ssum;
  logic [2:0] mi_q, mi_d;
  logic [1:0] di_q, di_d;
  logic       sing_q, sing_d;
  logic       div_start, div_busy, div_valid;
  logic signed [N-1:0] div_q;

  fxp_div_serial #(.N(N), .FRAC(FRAC)) u_div (
    .clk(clk), .rst(rst), .start(div_start), .num(div_num), .den(det_q),
    .busy(div_busy), .valid(div_valid), .q(div_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = SUM;
      SUM:  state_d = DET0;
      DET0: state_d = DET1;
      DET1: state_d = (det_nx <= 0) ? DONE : MUL;
      MUL:  if (mi_q == 3'd7) state_d = DIV;
      DIV:  if (div_valid && di_q == 2'd3) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (state_q inside {SUM, DET0, DET1, MUL, DIV});
    done     = (state_q == DONE);
    singular = sing_q;
    K00 = k_q[0]; K01 = k_q[1]; K10 = k_q[2]; K11 = k_q[3];
  end

  // Datapath
  always_comb begin
    p_d = p_q; r_d = r_q; s_d = s_q; acc_d = acc_q; det_d = det_q; n_d = n_q;
    kt_d = kt_q; mi_d = mi_q; di_d = di_q; k_d = k_q; sing_d = sing_q;
    ssum = '0;

    // Shared multiplier. In MUL, sub-index m picks P[{m2,m0}] * S[3-m[1:0]],
    // which walks 00a,00b,01a,01b,... ; terms m=1,2,5,6 carry the adj() minus.
    mul_a = s_q[0];
    mul_b = s_q[3];
    if (state_q == DET1) begin
      mul_a = s_q[1];
      mul_b = s_q[2];
    end else if (state_q == MUL) begin
      mul_a = p_q[{mi_q[2], mi_q[0]}];
      mul_b = s_q[~mi_q[1:0]];
    end
    prod    = mul_a * mul_b;
    prod_x  = (2*N+1)'(prod);
    term    = (mi_q[0] ^ mi_q[1]) ? -prod_x : prod_x;
    sum     = acc_q + term;
    diff    = acc_q - prod_x;
    shr_sum = sum >>> FRAC;
    shr_det = diff >>> FRAC;
    det_nx  = N'(sat_n(SAT_W'(shr_det), N));

    div_ext   = (2*N)'(n_q[di_q]);
    div_num   = div_ext <<< FRAC;
    div_start = (state_q == DIV) && !div_busy;

    case (state_q)
      IDLE: if (start) begin
        p_d = '{P00, P01, P10, P11};
        r_d = '{R11, R12, R21, R22};
      end
      SUM: for (int i = 0; i < 4; i++) begin
        ssum   = (N+1)'(p_q[i]) + (N+1)'(r_q[i]);
        s_d[i] = N'(sat_n(SAT_W'(ssum), N));
      end
      DET0: acc_d = prod_x;
      DET1: begin
        det_d = det_nx;
        if (det_nx <= 0) begin
          k_d    = '{default: '0};
          sing_d = 1'b1;
        end
      end
      MUL: begin
        mi_d = mi_q + 3'd1;
        if (!mi_q[0]) acc_d = term;
        else          n_d[mi_q[2:1]] = N'(sat_n(SAT_W'(shr_sum), N));
      end
      DIV: if (div_valid) begin
        di_d = di_q + 2'd1;
        // Quotients queue up in kt and publish together so K only moves at done.
        if (di_q == 2'd3) begin
          k_d    = '{kt_q[0], kt_q[1], kt_q[2], div_q};
          sing_d = 1'b0;
        end else begin
          kt_d[0] = kt_q[1];
          kt_d[1] = kt_q[2];
          kt_d[2] = div_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '{default: '0}; r_q <= '{default: '0}; s_q <= '{default: '0};
      n_q <= '{default: '0}; k_q <= '{default: '0}; kt_q <= '{default: '0};
      acc_q <= '0; det_q <= '0; mi_q <= '0; di_q <= '0; sing_q <= 1'b0;
    end else begin
      p_q <= p_d; r_q <= r_d; s_q <= s_d; n_q <= n_d; k_q <= k_d; kt_q <= kt_d;
      acc_q <= acc_d; det_q <= det_d; mi_q <= mi_d; di_q <= di_d; sing_q <= sing_d;
    end
  end
endmodule

// File: tb/tb_kgain_serial.sv
module tb_kgain_serial;
  localparam int N    = 20;
  localparam int FRAC = 10;
  localparam int MAXC = 320;
  typedef int m4_t [4];

  logic clk = 1'b0;
  logic rst, start;
  logic signed [N-1:0] tp [4];
  logic signed [N-1:0] tr [4];
  logic busy, done, singular;
  logic signed [N-1:0] K00, K01, K10, K11;

  int checks = 0;
  int failures = 0;

  int done_list [$];
  bit busy_h [MAXC];
  logic signed [N-1:0] kcap [4];
  logic scap;
  logic signed [N-1:0] kpost [4];
  logic bpost, dpost, spost;
  longint ek [4];
  bit esing;

  kgain_serial #(.N(N), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .P00(tp[0]), .P01(tp[1]), .P10(tp[2]), .P11(tp[3]),
    .R11(tr[0]), .R12(tr[1]), .R21(tr[2]), .R22(tr[3]),
    .busy(busy), .done(done), .singular(singular),
    .K00(K00), .K01(K01), .K10(K10), .K11(K11)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic longint sat(input longint x);
    longint hi, lo;
    hi = (longint'(1) <<< (N - 1)) - 1;
    lo = -hi - 1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // floor(x / 2^FRAC)
  function automatic longint fdiv(input longint x);
    longint m, qq;
    m  = longint'(1) <<< FRAC;
    qq = x / m;
    if ((x % m != 0) && (x < 0)) qq = qq - 1;
    return qq;
  endfunction

  task automatic model();
    longint p [4], r [4], s [4], n [4], d;
    for (int i = 0; i < 4; i++) begin
      p[i] = longint'(tp[i]);
      r[i] = longint'(tr[i]);
      s[i] = sat(p[i] + r[i]);
    end
    d = sat(fdiv(s[0] * s[3] - s[1] * s[2]));
    esing = (d <= 0);
    n[0] = sat(fdiv( p[0] * s[3] - p[1] * s[2]));
    n[1] = sat(fdiv(-p[0] * s[1] + p[1] * s[0]));
    n[2] = sat(fdiv( p[2] * s[3] - p[3] * s[2]));
    n[3] = sat(fdiv(-p[2] * s[1] + p[3] * s[0]));
    for (int i = 0; i < 4; i++)
      ek[i] = esing ? 0 : sat((n[i] * (longint'(1) <<< FRAC)) / d);
  endtask

  // ---------------- stimulus driver ----------------------------------------
  // Cycle 0 is the cycle whose closing edge samples start=1; samples are taken
  // on the falling edge inside each cycle.
  task automatic run_job(input int ncyc, input int pu1, input int pu2, input int pu3,
                         input int rst_at, input bit scramble);
    done_list.delete();
    for (int c = 0; c < MAXC; c++) busy_h[c] = 1'b0;
    @(negedge clk);
    start = 1'b1;
    rst   = 1'b0;
    for (int c = 1; c < ncyc; c++) begin
      @(negedge clk);
      busy_h[c] = busy;
      if (done) begin
        if (done_list.size() == 0) begin
          kcap = '{K00, K01, K10, K11};
          scap = singular;
        end
        done_list.push_back(c);
      end
      if (c == rst_at + 1) begin
        kpost = '{K00, K01, K10, K11};
        bpost = busy; dpost = done; spost = singular;
      end
      start = (c == pu1) || (c == pu2) || (c == pu3);
      rst   = (c == rst_at);
      if (scramble && c == 1)
        for (int j = 0; j < 4; j++) begin
          tp[j] = N'($urandom);
          tr[j] = N'($urandom);
        end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin tp[i] = '0; tr[i] = '0; end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (singular !== 1'b0) begin failures++; $display("FAIL reset_singular got=%0b exp=0", singular); end
    checks++;
    if ({K00, K01, K10, K11} !== '0) begin
      failures++; $display("FAIL reset_k got=%0d,%0d,%0d,%0d exp=0", K00, K01, K10, K11);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed(input string name, input m4_t p, input m4_t r,
                               input m4_t k, input bit sing, input int dcyc);
    int got, bad;
    for (int i = 0; i < 4; i++) begin tp[i] = N'(p[i]); tr[i] = N'(r[i]); end
    run_job(dcyc + 12, -1, -1, -1, -1, 1'b1);
    got = (done_list.size() > 0) ? done_list[0] : -1;
    checks++;
    if (done_list.size() != 1 || got != dcyc) begin
      failures++; $display("FAIL %s_done_cycle got=%0d count=%0d exp=%0d", name, got, done_list.size(), dcyc);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (kcap[i] !== N'(k[i])) begin
        failures++; $display("FAIL %s_k%0d got=%0d exp=%0d", name, i, kcap[i], k[i]);
      end
    end
    checks++;
    if (scap !== sing) begin failures++; $display("FAIL %s_singular got=%0b exp=%0b", name, scap, sing); end
    bad = 0;
    for (int c = 1; c < dcyc + 12; c++)
      if (busy_h[c] != (c < dcyc)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL %s_busy_window got=%0d bad cycles exp=0", name, bad); end
  endtask

  task automatic test_start_ignored();
    int n0, n1;
    for (int i = 0; i < 4; i++) begin tp[i] = '0; tr[i] = '0; end
    tp[0] = 20'sd1024; tp[3] = 20'sd1024; tr[0] = 20'sd1024; tr[3] = 20'sd1024;
    run_job(290, 40, 136, 137, -1, 1'b0);
    n0 = (done_list.size() > 0) ? done_list[0] : -1;
    n1 = (done_list.size() > 1) ? done_list[1] : -1;
    checks++;
    if (done_list.size() != 2) begin failures++; $display("FAIL ign_done_count got=%0d exp=2", done_list.size()); end
    checks++;
    if (n0 != 136) begin failures++; $display("FAIL ign_first_done got=%0d exp=136", n0); end
    checks++;
    if (n1 != 273) begin failures++; $display("FAIL ign_second_done got=%0d exp=273", n1); end
    checks++;
    if (kcap[0] !== 20'sd512 || kcap[3] !== 20'sd512) begin
      failures++; $display("FAIL ign_k got=%0d,%0d exp=512,512", kcap[0], kcap[3]);
    end
    checks++;
    if (busy_h[137] !== 1'b0 || busy_h[138] !== 1'b1) begin
      failures++; $display("FAIL ign_reaccept_busy got=%0b%0b exp=01", busy_h[137], busy_h[138]);
    end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 4; i++) begin tp[i] = '0; tr[i] = '0; end
    tp[0] = 20'sd1024; tp[3] = 20'sd1024; tr[0] = 20'sd1024; tr[3] = 20'sd1024;
    run_job(250, -1, -1, -1, 50, 1'b0);
    checks++;
    if (busy_h[50] !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%0b exp=1", busy_h[50]); end
    checks++;
    if ({kpost[0], kpost[1], kpost[2], kpost[3]} !== '0) begin
      failures++; $display("FAIL abort_k got=%0d,%0d,%0d,%0d exp=0", kpost[0], kpost[1], kpost[2], kpost[3]);
    end
    checks++;
    if (bpost !== 1'b0 || dpost !== 1'b0 || spost !== 1'b0) begin
      failures++; $display("FAIL abort_flags got=busy%0b done%0b sing%0b exp=000", bpost, dpost, spost);
    end
    checks++;
    if (done_list.size() != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_list.size()); end
  endtask

  task automatic test_random();
    int mode, got, exp_done;
    for (int it = 0; it < 10; it++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 4; i++) begin
        if (mode == 1) begin
          tp[i] = N'($urandom);
          tr[i] = N'($urandom);
        end else if (mode == 0) begin
          tp[i] = (i == 0 || i == 3) ? N'(int'($urandom_range(256, 16384)))
                                     : N'(int'($urandom_range(0, 4095)) - 2048);
          tr[i] = (i == 0 || i == 3) ? N'(int'($urandom_range(0, 8192)))
                                     : N'(int'($urandom_range(0, 511)) - 256);
        end else begin
          tp[i] = (i == 0 || i == 3) ? N'(int'($urandom_range(200000, 524287)))
                                     : N'(int'($urandom_range(0, 200000)) - 100000);
          tr[i] = N'(int'($urandom_range(0, 100000)));
        end
      end
      model();
      exp_done = esing ? 4 : 136;
      run_job(150, -1, -1, -1, -1, 1'b1);
      got = (done_list.size() > 0) ? done_list[0] : -1;
      checks++;
      if (done_list.size() != 1 || got != exp_done) begin
        failures++; $display("FAIL rnd%0d_done got=%0d exp=%0d", it, got, exp_done);
      end
      checks++;
      if (scap !== esing) begin failures++; $display("FAIL rnd%0d_singular got=%0b exp=%0b", it, scap, esing); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (kcap[i] !== N'(ek[i])) begin
          failures++; $display("FAIL rnd%0d_k%0d got=%0d exp=%0d", it, i, kcap[i], ek[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_directed("diag", '{1024, 0, 0, 1024}, '{1024, 0, 0, 1024}, '{512, 0, 0, 512}, 1'b0, 136);
    test_directed("full", '{2048, 1024, 1024, 2048}, '{0, 0, 0, 0}, '{1024, 0, 0, 1024}, 1'b0, 136);
    test_directed("zero", '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1, 4);
    test_directed("big", '{307200, 0, 0, 307200}, '{0, 0, 0, 0}, '{1024, 0, 0, 1024}, 1'b0, 136);
    test_start_ignored();
    test_reset_abort();
    test_directed("rerun", '{2048, 1024, 1024, 2048}, '{0, 0, 0, 0}, '{1024, 0, 0, 1024}, 1'b0, 136);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
